l2_arbiter: RTL



---
 rtl/l2_arb_pkg.sv | 19 +
 rtl/l2_arbiter_sat_counter32.sv | 32 +++
 rtl/l2_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/l2_arb_pkg.sv
// l2_arbiter shared types.
// FSM states, requester ids and default widths.
package l2_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_e;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_id_e;

endpackage

// File: rtl/l2_arbiter_sat_counter32.sv
// 32-bit saturating event counter.
// Holds at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // next value, pinned at the ceiling
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != 32'hFFFF_FFFF) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // count only on an increment strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin I/D arbiter for the single L2 port.
// One line transaction in flight; all outputs registered.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic [LINE_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [LINE_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [LINE_W-1:0] d_rdata_o,
  output logic              l2_req_o,
  output logic              l2_we_o,
  output logic [ADDR_W-1:0] l2_addr_o,
  output logic [LINE_W-1:0] l2_wdata_o,
  input  logic              l2_ack_i,
  input  logic [LINE_W-1:0] l2_rdata_i,
  output logic [31:0]       i_grant_cnt_o,
  output logic [31:0]       d_grant_cnt_o
);

  arb_state_e        state_q, state_d;
  req_id_e           grant_q, grant_d;
  req_id_e           last_q, last_d;
  logic              l2_req_q, l2_req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] resp_q, resp_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              i_inc, d_inc;
  logic              pick_i;

  // I wins if alone, or on a tie when D went last
  assign pick_i = i_req_i & (~d_req_i | (last_q == REQ_D));

  // next-state, grant and response capture
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    l2_req_d = l2_req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    resp_d   = resp_q;
    i_ack_d  = 1'b0;
    d_ack_d  = 1'b0;
    i_inc    = 1'b0;
    d_inc    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req_i | d_req_i) begin
          state_d  = BUSY;
          l2_req_d = 1'b1;
          if (pick_i) begin
            grant_d = REQ_I;
            addr_d  = i_addr_i;
            we_d    = 1'b0;
            wdata_d = '0;
            i_inc   = 1'b1;
          end else begin
            grant_d = REQ_D;
            addr_d  = d_addr_i;
            we_d    = d_we_i;
            wdata_d = d_wdata_i;
            d_inc   = 1'b1;
          end
        end
      end
      BUSY: begin
        if (l2_ack_i) begin
          state_d  = RESP;
          l2_req_d = 1'b0;
          resp_d   = l2_rdata_i;
          i_ack_d  = (grant_q == REQ_I);
          d_ack_d  = (grant_q == REQ_D);
        end
      end
      RESP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= REQ_I;
      last_q   <= REQ_D;
      l2_req_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      l2_req_q <= l2_req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      resp_q   <= resp_d;
      i_ack_q  <= i_ack_d;
      d_ack_q  <= d_ack_d;
    end
  end

  sat_counter32 u_i_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (i_inc),
    .cnt_o (i_grant_cnt_o)
  );

  sat_counter32 u_d_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (d_inc),
    .cnt_o (d_grant_cnt_o)
  );

  assign l2_req_o   = l2_req_q;
  assign l2_we_o    = we_q;
  assign l2_addr_o  = addr_q;
  assign l2_wdata_o = wdata_q;
  assign i_ack_o    = i_ack_q;
  assign d_ack_o    = d_ack_q;
  assign i_rdata_o  = resp_q;
  assign d_rdata_o  = resp_q;

endmodule
